// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC owner, icache request, fetch->decode latch
//
// Purpose:
//   Holds the program counter, issues instruction reads to the icache, applies
//   redirects from the branch/prediction unit and writes the fetch->decode latch.
//
// Ports:
//   CLK, nRST          clock (rising edge) and asynchronous active-low reset
//   stall              hold PC and fd latch
//   halt               HALT decoded; stop fetching
//   misc_npc_en        override next PC with misc_npc on a hit
//   misc_npc           redirect / predicted target
//   cancel_fetch       word currently being fetched is wrong-path
//   squash             instruction in the fd latch is wrong-path
//   branch_taken       prediction for the current PC
//   ihit, imemload     icache response
//   imemREN, imemaddr  icache request
//   npc_default        pc + 4, fed back to the branch unit
//   fd_*               fetch->decode latch contents

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        stall,
  input  logic        halt,
  input  logic        misc_npc_en,
  input  logic [31:0] misc_npc,
  input  logic        cancel_fetch,
  input  logic        squash,
  input  logic        branch_taken,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] npc_default,
  output logic        fd_valid,
  output logic [31:0] fd_instruction,
  output logic [31:0] fd_instr_npc,
  output logic        fd_branch_taken
);

  typedef enum logic [1:0] {
    S_FETCH         = 2'd0,
    S_REDIRECT_WAIT = 2'd1,
    S_HALTED        = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_npc;
  logic        r_fd_valid;
  logic [31:0] r_fd_instruction;
  logic [31:0] r_fd_instr_npc;
  logic        r_fd_branch_taken;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_pend_next;
  logic [31:0] w_pc_plus4;
  logic        w_fd_load;
  logic        w_fd_clear;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_pend_next  = r_pend_npc;
    w_fd_load    = 1'b0;
    w_fd_clear   = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (halt && !squash) begin
          w_state_next = S_HALTED;
          w_fd_clear   = 1'b1;
        end else if (cancel_fetch && ihit) begin
          w_pc_next  = misc_npc;
          w_fd_clear = !stall;
        end else if (cancel_fetch) begin
          // The icache cannot abort the outstanding read, so park the target
          // and keep imemaddr stable until the hit arrives.
          w_pend_next  = misc_npc;
          w_state_next = S_REDIRECT_WAIT;
          w_fd_clear   = !stall;
        end else if (ihit && !stall) begin
          w_fd_load = 1'b1;
          w_pc_next = misc_npc_en ? misc_npc : w_pc_plus4;
        end
      end
      S_REDIRECT_WAIT: begin
        // halt is ignored here: anything decoded now is wrong-path.
        w_fd_clear = !stall;
        if (cancel_fetch) begin
          w_pend_next = misc_npc;
        end
        if (ihit) begin
          // The returned word belongs to the cancelled path and is dropped.
          w_pc_next    = cancel_fetch ? misc_npc : r_pend_npc;
          w_state_next = S_FETCH;
        end
      end
      S_HALTED: begin
        w_fd_clear = 1'b1;
      end
      default: begin
        w_state_next = S_FETCH;
        w_fd_clear   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_pend_npc <= 32'd0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_pend_npc <= w_pend_next;
    end
  end

  // squash wins over every other fd rule, including stall.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fd_valid        <= 1'b0;
      r_fd_instruction  <= 32'd0;
      r_fd_instr_npc    <= 32'd0;
      r_fd_branch_taken <= 1'b0;
    end else if (squash || w_fd_clear) begin
      r_fd_valid        <= 1'b0;
      r_fd_instruction  <= 32'd0;
      r_fd_instr_npc    <= 32'd0;
      r_fd_branch_taken <= 1'b0;
    end else if (w_fd_load) begin
      r_fd_valid        <= 1'b1;
      r_fd_instruction  <= imemload;
      r_fd_instr_npc    <= w_pc_plus4;
      r_fd_branch_taken <= branch_taken;
    end
  end

  assign imemREN         = (r_state != S_HALTED);
  assign imemaddr        = r_pc;
  assign npc_default     = w_pc_plus4;
  assign fd_valid        = r_fd_valid;
  assign fd_instruction  = r_fd_instruction;
  assign fd_instr_npc    = r_fd_instr_npc;
  assign fd_branch_taken = r_fd_branch_taken;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage

module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        misc_npc_en = 1'b0;
  logic [31:0] misc_npc = 32'd0;
  logic        cancel_fetch = 1'b0;
  logic        squash = 1'b0;
  logic        branch_taken = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] imemload = 32'd0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] npc_default;
  logic        fd_valid;
  logic [31:0] fd_instruction;
  logic [31:0] fd_instr_npc;
  logic        fd_branch_taken;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .stall(stall), .halt(halt),
    .misc_npc_en(misc_npc_en), .misc_npc(misc_npc),
    .cancel_fetch(cancel_fetch), .squash(squash), .branch_taken(branch_taken),
    .ihit(ihit), .imemload(imemload), .imemREN(imemREN), .imemaddr(imemaddr),
    .npc_default(npc_default), .fd_valid(fd_valid), .fd_instruction(fd_instruction),
    .fd_instr_npc(fd_instr_npc), .fd_branch_taken(fd_branch_taken)
  );

  always #5 CLK = ~CLK;

  // Reference model: the fetch PC, a parked redirect target, whether a
  // cancelled miss is still outstanding, whether the core has halted, and the
  // four fields decode will see.
  logic [31:0] m_pc, m_pend;
  bit          m_waiting, m_halted;
  logic        m_v, m_b;
  logic [31:0] m_i, m_n;

  task automatic model_reset();
    m_pc = 32'h0; m_pend = 32'h0; m_waiting = 0; m_halted = 0;
    m_v = 0; m_i = 0; m_n = 0; m_b = 0;
  endtask

  task automatic model_bubble();
    m_v = 0; m_i = 0; m_n = 0; m_b = 0;
  endtask

  task automatic model_step();
    bit keep_fd;
    keep_fd = 1;
    if (m_halted) begin
      keep_fd = 0;
    end else if (m_waiting) begin
      if (cancel_fetch) m_pend = misc_npc;
      if (ihit) begin
        m_pc = m_pend;
        m_waiting = 0;
      end
      keep_fd = stall;
    end else if (halt && !squash) begin
      m_halted = 1;
      keep_fd = 0;
    end else if (cancel_fetch) begin
      if (ihit) m_pc = misc_npc;
      else begin
        m_pend = misc_npc;
        m_waiting = 1;
      end
      keep_fd = stall;
    end else if (ihit && !stall) begin
      m_v = 1; m_i = imemload; m_n = m_pc + 4; m_b = branch_taken;
      m_pc = misc_npc_en ? misc_npc : m_pc + 4;
    end
    if (!keep_fd || squash) model_bubble();
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic check_model(input string tag, input int idx);
    check({tag, ".imemaddr"}, idx, imemaddr, m_pc);
    check({tag, ".imemREN"}, idx, {31'd0, imemREN}, {31'd0, !m_halted});
    check({tag, ".npc_default"}, idx, npc_default, m_pc + 32'd4);
    check({tag, ".fd_valid"}, idx, {31'd0, fd_valid}, {31'd0, m_v});
    check({tag, ".fd_instruction"}, idx, fd_instruction, m_i);
    check({tag, ".fd_instr_npc"}, idx, fd_instr_npc, m_n);
    check({tag, ".fd_branch_taken"}, idx, {31'd0, fd_branch_taken}, {31'd0, m_b});
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    model_reset();
    check_model("reset", 0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic clk_step();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  typedef struct {
    logic        st, hl, en;
    logic [31:0] npc;
    logic        cf, sq, bt, ih;
    logic [31:0] ld;
    logic [31:0] e_addr;
    logic        e_ren, e_v;
    logic [31:0] e_i, e_n;
    logic        e_b;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{0,0,0,32'h00,0,0,0,1,32'h11, 32'h04,1,1,32'h11,32'h04,0};
    vecs[1]  = '{0,0,0,32'h00,0,0,0,1,32'h22, 32'h08,1,1,32'h22,32'h08,0};
    vecs[2]  = '{1,0,0,32'h00,0,0,0,1,32'h33, 32'h08,1,1,32'h22,32'h08,0};
    vecs[3]  = '{1,0,0,32'h00,0,0,0,1,32'h33, 32'h08,1,1,32'h22,32'h08,0};
    vecs[4]  = '{0,0,0,32'h00,0,0,0,1,32'h33, 32'h0C,1,1,32'h33,32'h0C,0};
    vecs[5]  = '{1,0,0,32'h00,0,1,0,1,32'h34, 32'h0C,1,0,32'h00,32'h00,0};
    vecs[6]  = '{0,0,0,32'h00,0,0,0,1,32'h44, 32'h10,1,1,32'h44,32'h10,0};
    vecs[7]  = '{0,0,1,32'h40,0,0,1,1,32'h55, 32'h40,1,1,32'h55,32'h14,1};
    vecs[8]  = '{0,0,0,32'h20,1,0,0,1,32'h66, 32'h20,1,0,32'h00,32'h00,0};
    vecs[9]  = '{0,0,0,32'h80,1,0,0,0,32'h00, 32'h20,1,0,32'h00,32'h00,0};
    vecs[10] = '{0,1,0,32'h00,0,0,0,0,32'h00, 32'h20,1,0,32'h00,32'h00,0};
    vecs[11] = '{0,0,0,32'h00,0,0,0,0,32'h00, 32'h20,1,0,32'h00,32'h00,0};
    vecs[12] = '{0,0,0,32'h00,0,0,0,1,32'h77, 32'h80,1,0,32'h00,32'h00,0};
    vecs[13] = '{0,0,0,32'h00,0,0,0,1,32'h88, 32'h84,1,1,32'h88,32'h84,0};
    vecs[14] = '{0,1,0,32'h00,0,0,0,1,32'h99, 32'h84,0,0,32'h00,32'h00,0};
    vecs[15] = '{0,0,0,32'h00,0,0,0,1,32'hAA, 32'h84,0,0,32'h00,32'h00,0};

    // Reset state (asynchronous, visible before any edge).
    #2;
    model_reset();
    check_model("reset", 0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // Directed table.
    for (int k = 0; k < 16; k++) begin
      stall = vecs[k].st; halt = vecs[k].hl; misc_npc_en = vecs[k].en;
      misc_npc = vecs[k].npc; cancel_fetch = vecs[k].cf; squash = vecs[k].sq;
      branch_taken = vecs[k].bt; ihit = vecs[k].ih; imemload = vecs[k].ld;
      clk_step();
      check("vec.imemaddr", k, imemaddr, vecs[k].e_addr);
      check("vec.imemREN", k, {31'd0, imemREN}, {31'd0, vecs[k].e_ren});
      check("vec.npc_default", k, npc_default, vecs[k].e_addr + 32'd4);
      check("vec.fd_valid", k, {31'd0, fd_valid}, {31'd0, vecs[k].e_v});
      check("vec.fd_instruction", k, fd_instruction, vecs[k].e_i);
      check("vec.fd_instr_npc", k, fd_instr_npc, vecs[k].e_n);
      check("vec.fd_branch_taken", k, {31'd0, fd_branch_taken}, {31'd0, vecs[k].e_b});
    end

    // Halted core leaves only via reset.
    stall = 0; halt = 0; misc_npc_en = 0; cancel_fetch = 0; squash = 0;
    branch_taken = 0; ihit = 1; imemload = 32'h1;
    do_reset();

    // Reset in the middle of a cancelled miss.
    cancel_fetch = 1; misc_npc = 32'h100; ihit = 0;
    clk_step();
    check_model("midmiss", 0);
    cancel_fetch = 0;
    #2;
    do_reset();
    ihit = 1; imemload = 32'h5;
    clk_step();
    check_model("restart", 0);
    check("restart.fd", 0, fd_instruction, 32'h5);

    // Newest redirect target wins while waiting on a miss.
    ihit = 0; cancel_fetch = 1; misc_npc = 32'h200;
    clk_step();
    misc_npc = 32'h300;
    clk_step();
    cancel_fetch = 0;
    clk_step();
    ihit = 1;
    clk_step();
    check("newest.imemaddr", 0, imemaddr, 32'h300);

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      if (m_halted && $urandom_range(0, 7) == 0) begin
        do_reset();
      end
      stall        = ($urandom_range(0, 3) == 0);
      halt         = ($urandom_range(0, 39) == 0);
      misc_npc_en  = ($urandom_range(0, 3) == 0);
      misc_npc     = {$urandom_range(0, 32'h3FFF), 2'b00};
      cancel_fetch = ($urandom_range(0, 5) == 0);
      squash       = ($urandom_range(0, 7) == 0);
      branch_taken = $urandom_range(0, 1);
      ihit         = ($urandom_range(0, 3) != 0);
      imemload     = $urandom;
      clk_step();
      check_model("rand", c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
